// File: rtl/fwd_hazard_unit_pkg.sv
// -----------------------------------------------------------------------------
// fwd_hazard_unit_pkg
// Shared pipeline definitions for the decode-stage hazard/forwarding logic.
//   - FWD_* : operand select encoding consumed by the execute operand mux
//   - REG_AW : architectural register index width
//   - sbEntry_t : one scoreboard slot {rd, wen, load} tracked per stage
// -----------------------------------------------------------------------------
package fwd_hazard_unit_pkg;

    localparam int REG_AW = 5;

    // Operand select encoding seen by the execute-stage mux
    localparam logic [1:0] FWD_WB   = 2'b00;
    localparam logic [1:0] FWD_ALU  = 2'b01;
    localparam logic [1:0] FWD_RF   = 2'b10;
    localparam logic [1:0] FWD_ZERO = 2'b11;

    // Width of the load-use stall down-counter (covers up to 3 bubbles)
    localparam int STALL_CNT_W = 2;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic              wen;
        logic              load;
    } sbEntry_t;

    localparam sbEntry_t SB_NOP = '{rd: '0, wen: 1'b0, load: 1'b0};

endpackage : fwd_hazard_unit_pkg

// File: rtl/fwd_hazard_unit_select.sv
// -----------------------------------------------------------------------------
// fwd_select
// Combinational forwarding priority for a single decode source operand.
// The decode instruction moves into E at the next edge, so the producer now in
// E will be in M (result on alu_out) and the producer now in M will be in W
// (result on wb_data) when this operand is consumed.
// Ports:
//   srcIdx_i  : decode source register index
//   useSrc_i  : instruction actually reads this source
//   eEntry_i  : scoreboard entry of the instruction in E
//   mEntry_i  : scoreboard entry of the instruction in M
//   sel_o     : FWD_* select for this source
// -----------------------------------------------------------------------------
module fwd_select
    import fwd_hazard_unit_pkg::*;
(
    input  logic [REG_AW-1:0] srcIdx_i,
    input  logic              useSrc_i,
    input  sbEntry_t          eEntry_i,
    input  sbEntry_t          mEntry_i,
    output logic [1:0]        sel_o
);

    // Priority chain: x0/unused first, then the youngest producer (E), then M.
    // A load in E is skipped here because its data is not on alu_out; that case
    // is handled by the load-use stall, after which the load sits in M.
    always_comb begin
        sel_o = FWD_RF;
        if ((srcIdx_i == '0) || !useSrc_i) begin
            sel_o = FWD_ZERO;
        end else if (eEntry_i.wen && (eEntry_i.rd == srcIdx_i) && !eEntry_i.load) begin
            sel_o = FWD_ALU;
        end else if (mEntry_i.wen && (mEntry_i.rd == srcIdx_i)) begin
            sel_o = FWD_WB;
        end
    end

endmodule : fwd_select

// File: rtl/fwd_hazard_unit.sv
// -----------------------------------------------------------------------------
// fwd_hazard_unit
// Decode-stage hazard and forwarding controller. Keeps a two-entry scoreboard
// (E and M stages), registers the operand selects for the execute mux, and
// raises stall/bubble/flush controls for the IF/ID/EX pipeline registers.
// W is not tracked: the register file is write-first, so a W-stage write is
// already visible to the decode read.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   D_valid .. D_is_load     : decode-slot instruction description
//   E_branch_taken           : execute stage redirects the PC this cycle
//   stall_if, stall_id       : hold PC/IF-ID and the decode slot (combinational)
//   bubble_ex                : load a NOP into ID/EX (combinational)
//   flush_id                 : squash IF/ID (combinational)
//   E_rs1_data_sel/E_rs2_... : registered operand selects, valid in the E cycle
// -----------------------------------------------------------------------------
module fwd_hazard_unit #(
    parameter int REG_AW     = fwd_hazard_unit_pkg::REG_AW,
    parameter int LOAD_STALL = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              D_valid,
    input  logic [REG_AW-1:0] D_rs1,
    input  logic [REG_AW-1:0] D_rs2,
    input  logic              D_use_rs1,
    input  logic              D_use_rs2,
    input  logic [REG_AW-1:0] D_rd,
    input  logic              D_reg_write,
    input  logic              D_is_load,
    input  logic              E_branch_taken,
    output logic              stall_if,
    output logic              stall_id,
    output logic              bubble_ex,
    output logic              flush_id,
    output logic [1:0]        E_rs1_data_sel,
    output logic [1:0]        E_rs2_data_sel
);

    import fwd_hazard_unit_pkg::*;

    localparam logic [STALL_CNT_W-1:0] STALL_RELOAD = STALL_CNT_W'(LOAD_STALL - 1);

    sbEntry_t                eEntry_q;
    sbEntry_t                eEntry_d;
    sbEntry_t                mEntry_q;
    logic [STALL_CNT_W-1:0]  stallCnt_q;
    logic [STALL_CNT_W-1:0]  stallCnt_d;
    logic [1:0]              rs1Sel_q;
    logic [1:0]              rs1Sel_d;
    logic [1:0]              rs2Sel_q;
    logic [1:0]              rs2Sel_d;

    logic [1:0]              rs1Fwd;
    logic [1:0]              rs2Fwd;
    logic                    rs1LoadHit;
    logic                    rs2LoadHit;
    logic                    loadUse;
    logic                    countdown;
    logic                    stallReq;
    logic                    flushReq;

    fwd_select u_rs1Select (
        .srcIdx_i (D_rs1),
        .useSrc_i (D_use_rs1),
        .eEntry_i (eEntry_q),
        .mEntry_i (mEntry_q),
        .sel_o    (rs1Fwd)
    );

    fwd_select u_rs2Select (
        .srcIdx_i (D_rs2),
        .useSrc_i (D_use_rs2),
        .eEntry_i (eEntry_q),
        .mEntry_i (mEntry_q),
        .sel_o    (rs2Fwd)
    );

    // Load-use detection against the load currently in E. While the counter
    // is running the stall is held without looking at the hazard again; after
    // the first bubble the load has moved on to M anyway.
    always_comb begin
        rs1LoadHit = D_use_rs1 && (D_rs1 == eEntry_q.rd);
        rs2LoadHit = D_use_rs2 && (D_rs2 == eEntry_q.rd);
        loadUse    = D_valid && eEntry_q.load && eEntry_q.wen &&
                     (eEntry_q.rd != '0) && (rs1LoadHit || rs2LoadHit);
        countdown  = (stallCnt_q != '0);
        stallReq   = countdown || loadUse;
        flushReq   = E_branch_taken;
    end

    // Control outputs are pure combinational so the pipeline registers react in
    // the same cycle. A taken branch wins over a stall: the decode slot is being
    // squashed, so holding it would be pointless.
    always_comb begin
        flush_id  = flushReq;
        stall_if  = stallReq && !flushReq;
        stall_id  = stallReq && !flushReq;
        bubble_ex = stallReq || flushReq;
    end

    // Next-state for the scoreboard, stall counter and operand selects. A bubble
    // or an invalid decode slot enters E as a NOP so it never forwards. Selects
    // go to zero on flush (the E slot is a NOP) and to the register file during
    // a stall, matching the bubble that enters E alongside them.
    always_comb begin
        eEntry_d   = SB_NOP;
        stallCnt_d = '0;
        rs1Sel_d   = rs1Fwd;
        rs2Sel_d   = rs2Fwd;

        if (!bubble_ex && D_valid) begin
            eEntry_d = '{rd: D_rd, wen: D_reg_write, load: D_is_load};
        end

        if (flushReq) begin
            stallCnt_d = '0;
            rs1Sel_d   = FWD_ZERO;
            rs2Sel_d   = FWD_ZERO;
        end else if (stallReq) begin
            stallCnt_d = countdown ? (stallCnt_q - 1'b1) : STALL_RELOAD;
            rs1Sel_d   = FWD_RF;
            rs2Sel_d   = FWD_RF;
        end
    end

    // State registers. Reset clears the scoreboard and counter so a stall in
    // progress is abandoned at the reset edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            eEntry_q   <= SB_NOP;
            mEntry_q   <= SB_NOP;
            stallCnt_q <= '0;
            rs1Sel_q   <= FWD_RF;
            rs2Sel_q   <= FWD_RF;
        end else begin
            mEntry_q   <= eEntry_q;
            eEntry_q   <= eEntry_d;
            stallCnt_q <= stallCnt_d;
            rs1Sel_q   <= rs1Sel_d;
            rs2Sel_q   <= rs2Sel_d;
        end
    end

    assign E_rs1_data_sel = rs1Sel_q;
    assign E_rs2_data_sel = rs2Sel_q;

endmodule : fwd_hazard_unit

// File: tb/tb_fwd_hazard_unit.sv
// -----------------------------------------------------------------------------
// tb_fwd_hazard_unit
// Drives three copies of the unit (LOAD_STALL = 1, 2, 3) with the same decode
// stream. A behavioural model of the pipeline (what instruction sits in E and
// M, how many stall cycles remain) predicts every output each cycle; directed
// sequences with hand-computed values pin the model before random traffic.
// -----------------------------------------------------------------------------
module tb_fwd_hazard_unit;

    localparam int NDUT = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       D_valid = 1'b0;
    logic [4:0] D_rs1 = '0;
    logic [4:0] D_rs2 = '0;
    logic       D_use_rs1 = 1'b0;
    logic       D_use_rs2 = 1'b0;
    logic [4:0] D_rd = '0;
    logic       D_reg_write = 1'b0;
    logic       D_is_load = 1'b0;
    logic       E_branch_taken = 1'b0;

    logic       stallIf  [NDUT];
    logic       stallId  [NDUT];
    logic       bubbleEx [NDUT];
    logic       flushId  [NDUT];
    logic [1:0] sel1     [NDUT];
    logic [1:0] sel2     [NDUT];

    int checks = 0;
    int errors = 0;
    bit armed  = 1'b0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : gDut
        fwd_hazard_unit #(.REG_AW(5), .LOAD_STALL(g + 1)) dut (
            .clk            (clk),
            .rst            (rst),
            .D_valid        (D_valid),
            .D_rs1          (D_rs1),
            .D_rs2          (D_rs2),
            .D_use_rs1      (D_use_rs1),
            .D_use_rs2      (D_use_rs2),
            .D_rd           (D_rd),
            .D_reg_write    (D_reg_write),
            .D_is_load      (D_is_load),
            .E_branch_taken (E_branch_taken),
            .stall_if       (stallIf[g]),
            .stall_id       (stallId[g]),
            .bubble_ex      (bubbleEx[g]),
            .flush_id       (flushId[g]),
            .E_rs1_data_sel (sel1[g]),
            .E_rs2_data_sel (sel2[g])
        );
    end

    // Shared comparison helper used by both the model checker and the directed tests
    task automatic checkOutput(input string name, input int dutIdx,
                               input logic [1:0] actual, input logic [1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s dut%0d (LOAD_STALL=%0d) actual=%0d expected=%0d at %0t",
                     name, dutIdx, dutIdx + 1, actual, expected, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: instructions occupying E and M, remaining stall
    // cycles and the selects that the next E cycle should present.
    // ------------------------------------------------------------------
    typedef struct {
        int rd;
        bit wen;
        bit ld;
    } instRec_t;

    instRec_t inE [NDUT];
    instRec_t inM [NDUT];
    int       stallLeft [NDUT];
    int       expSel1 [NDUT];
    int       expSel2 [NDUT];

    function automatic int srcSel(int idx, bit used, instRec_t e, instRec_t m);
        if (idx == 0 || !used) return 3;
        if (e.wen && e.rd == idx && !e.ld) return 1;
        if (m.wen && m.rd == idx) return 0;
        return 2;
    endfunction

    initial begin
        for (int k = 0; k < NDUT; k++) begin
            inE[k] = '{0, 1'b0, 1'b0};
            inM[k] = '{0, 1'b0, 1'b0};
            stallLeft[k] = 0;
            expSel1[k] = 2;
            expSel2[k] = 2;
        end
    end

    // Compare process: at every falling edge check the DUTs against the model,
    // then advance the model to what the next rising edge should produce
    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < NDUT; k++) begin
                instRec_t e;
                instRec_t incoming;
                bit hazard;
                bit holding;
                bit expStall;
                bit expBubble;
                bit expFlush;
                e = inE[k];
                hazard = D_valid && e.ld && e.wen && e.rd != 0 &&
                         ((D_use_rs1 && int'(D_rs1) == e.rd) ||
                          (D_use_rs2 && int'(D_rs2) == e.rd));
                holding   = (stallLeft[k] > 0) || hazard;
                expFlush  = E_branch_taken;
                expStall  = holding && !expFlush;
                expBubble = holding || expFlush;

                if (armed) begin
                    checkOutput("model_stall_if",  k, {1'b0, stallIf[k]},  {1'b0, expStall});
                    checkOutput("model_stall_id",  k, {1'b0, stallId[k]},  {1'b0, expStall});
                    checkOutput("model_bubble_ex", k, {1'b0, bubbleEx[k]}, {1'b0, expBubble});
                    checkOutput("model_flush_id",  k, {1'b0, flushId[k]},  {1'b0, expFlush});
                    checkOutput("model_sel1",      k, sel1[k], 2'(expSel1[k]));
                    checkOutput("model_sel2",      k, sel2[k], 2'(expSel2[k]));
                end

                if (rst) begin
                    inE[k] = '{0, 1'b0, 1'b0};
                    inM[k] = '{0, 1'b0, 1'b0};
                    stallLeft[k] = 0;
                    expSel1[k] = 2;
                    expSel2[k] = 2;
                end else begin
                    if (expFlush) begin
                        expSel1[k] = 3;
                        expSel2[k] = 3;
                    end else if (holding) begin
                        expSel1[k] = 2;
                        expSel2[k] = 2;
                    end else begin
                        expSel1[k] = srcSel(int'(D_rs1), D_use_rs1, inE[k], inM[k]);
                        expSel2[k] = srcSel(int'(D_rs2), D_use_rs2, inE[k], inM[k]);
                    end

                    if (expFlush)              stallLeft[k] = 0;
                    else if (stallLeft[k] > 0) stallLeft[k] = stallLeft[k] - 1;
                    else if (hazard)           stallLeft[k] = k;
                    else                       stallLeft[k] = 0;

                    if (expBubble || !D_valid) incoming = '{0, 1'b0, 1'b0};
                    else                       incoming = '{int'(D_rd), D_reg_write, D_is_load};
                    inM[k] = inE[k];
                    inE[k] = incoming;
                end
            end
        end
    end

    // Present one decode-slot instruction; returns 1 time unit later so
    // combinational outputs can be sampled before the next edge
    task automatic applyStimulus(input bit v, input int rs1, input int rs2,
                                 input bit u1, input bit u2, input int rd,
                                 input bit rw, input bit ld, input bit br);
        D_valid        = v;
        D_rs1          = 5'(rs1);
        D_rs2          = 5'(rs2);
        D_use_rs1      = u1;
        D_use_rs2      = u2;
        D_rd           = 5'(rd);
        D_reg_write    = rw;
        D_is_load      = ld;
        E_branch_taken = br;
        #1;
    endtask

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    // Directed sequences with hand-derived values, then randomized traffic
    initial begin
        stepClock();
        armed = 1'b1;
        stepClock();
        for (int k = 0; k < NDUT; k++) begin
            checkOutput("reset_sel1",     k, sel1[k], 2'b10);
            checkOutput("reset_sel2",     k, sel2[k], 2'b10);
            checkOutput("reset_stall_if", k, {1'b0, stallIf[k]}, 2'b00);
            checkOutput("reset_bubble",   k, {1'b0, bubbleEx[k]}, 2'b00);
        end
        rst = 1'b0;

        // add x5,x1,x2 ; sub x6,x5,x1
        applyStimulus(1, 1, 2, 1, 1, 5, 1, 0, 0);
        stepClock();
        applyStimulus(1, 5, 1, 1, 1, 6, 1, 0, 0);
        checkOutput("alu_b2b_stall", 0, {1'b0, stallIf[0]}, 2'b00);
        stepClock();
        checkOutput("alu_b2b_sel1", 0, sel1[0], 2'b01);
        checkOutput("alu_b2b_sel2", 0, sel2[0], 2'b10);

        // add x5 ; nop ; or x7,x5,x5
        applyStimulus(1, 1, 2, 1, 1, 5, 1, 0, 0);
        stepClock();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        stepClock();
        applyStimulus(1, 5, 5, 1, 1, 7, 1, 0, 0);
        stepClock();
        checkOutput("dist2_sel1", 0, sel1[0], 2'b00);
        checkOutput("dist2_sel2", 0, sel2[0], 2'b00);

        // lw x8,0(x3) ; add x9,x8,x2 held in decode through the stall
        applyStimulus(1, 3, 0, 1, 0, 8, 1, 1, 0);
        stepClock();
        applyStimulus(1, 8, 2, 1, 1, 9, 1, 0, 0);
        for (int k = 0; k < NDUT; k++)
            checkOutput("loaduse_stall_c1", k, {1'b0, stallIf[k]}, 2'b01);
        checkOutput("loaduse_stall_id_c1", 0, {1'b0, stallId[0]}, 2'b01);
        checkOutput("loaduse_bubble_c1",   0, {1'b0, bubbleEx[0]}, 2'b01);
        stepClock();
        checkOutput("loaduse_stall_c2", 0, {1'b0, stallIf[0]}, 2'b00);
        checkOutput("loaduse_stall_c2", 1, {1'b0, stallIf[1]}, 2'b01);
        checkOutput("loaduse_stall_c2", 2, {1'b0, stallIf[2]}, 2'b01);
        checkOutput("loaduse_bubble_sel1", 0, sel1[0], 2'b10);
        checkOutput("loaduse_bubble_sel2", 0, sel2[0], 2'b10);
        stepClock();
        checkOutput("loaduse_fwd_sel1", 0, sel1[0], 2'b00);
        checkOutput("loaduse_fwd_sel2", 0, sel2[0], 2'b10);
        checkOutput("loaduse_stall_c3", 1, {1'b0, stallIf[1]}, 2'b00);
        checkOutput("loaduse_stall_c3", 2, {1'b0, stallIf[2]}, 2'b01);
        stepClock();
        checkOutput("loaduse_stall_c4", 2, {1'b0, stallIf[2]}, 2'b00);

        // lw x0 ; add x3,x0,x0
        applyStimulus(1, 3, 0, 1, 0, 0, 1, 1, 0);
        stepClock();
        applyStimulus(1, 0, 0, 1, 1, 3, 1, 0, 0);
        for (int k = 0; k < NDUT; k++)
            checkOutput("x0_no_stall", k, {1'b0, stallIf[k]}, 2'b00);
        stepClock();
        checkOutput("x0_sel1", 0, sel1[0], 2'b11);
        checkOutput("x0_sel2", 0, sel2[0], 2'b11);

        // lw x8 ; add x9,x8,x2 with a taken branch in the hazard cycle
        applyStimulus(1, 3, 0, 1, 0, 8, 1, 1, 0);
        stepClock();
        applyStimulus(1, 8, 2, 1, 1, 9, 1, 0, 1);
        checkOutput("flush_flush_id", 2, {1'b0, flushId[2]},  2'b01);
        checkOutput("flush_stall_if", 2, {1'b0, stallIf[2]},  2'b00);
        checkOutput("flush_stall_id", 2, {1'b0, stallId[2]},  2'b00);
        checkOutput("flush_bubble",   2, {1'b0, bubbleEx[2]}, 2'b01);
        stepClock();
        checkOutput("flush_sel1", 2, sel1[2], 2'b11);
        checkOutput("flush_sel2", 2, sel2[2], 2'b11);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("flush_cnt_clear", 2, {1'b0, stallIf[2]},  2'b00);
        checkOutput("flush_no_bubble", 2, {1'b0, bubbleEx[2]}, 2'b00);
        stepClock();

        // Reset arriving in the middle of a three-cycle stall
        applyStimulus(1, 3, 0, 1, 0, 8, 1, 1, 0);
        stepClock();
        applyStimulus(1, 8, 2, 1, 1, 9, 1, 0, 0);
        checkOutput("rst_mid_stall_c1", 2, {1'b0, stallIf[2]}, 2'b01);
        stepClock();
        rst = 1'b1;
        #1;
        checkOutput("rst_mid_stall_c2", 2, {1'b0, stallIf[2]}, 2'b01);
        stepClock();
        checkOutput("rst_after_stall_if",  2, {1'b0, stallIf[2]},  2'b00);
        checkOutput("rst_after_stall_id",  2, {1'b0, stallId[2]},  2'b00);
        checkOutput("rst_after_bubble",    2, {1'b0, bubbleEx[2]}, 2'b00);
        checkOutput("rst_after_flush",     2, {1'b0, flushId[2]},  2'b00);
        checkOutput("rst_after_sel1",      2, sel1[2], 2'b10);
        checkOutput("rst_after_sel2",      2, sel2[2], 2'b10);
        rst = 1'b0;

        // Randomized traffic over a small register range so hazards are frequent
        for (int i = 0; i < 3000; i++) begin
            bit ld;
            rst = ($urandom_range(0, 99) < 2);
            ld  = ($urandom_range(0, 99) < 35);
            applyStimulus($urandom_range(0, 99) < 85,
                          $urandom_range(0, 3), $urandom_range(0, 3),
                          $urandom_range(0, 99) < 80, $urandom_range(0, 99) < 60,
                          $urandom_range(0, 3),
                          ld || ($urandom_range(0, 99) < 75), ld,
                          $urandom_range(0, 99) < 6);
            stepClock();
        end

        rst = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        stepClock();
        stepClock();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_fwd_hazard_unit

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Decode-stage hazard and forwarding controller; direct upstream feeder of the execute-stage operand mux.
- Tracks destination registers of instructions in the E and M stages with an internal scoreboard.
- Produces the registered E_rs1_data_sel/E_rs2_data_sel that the execute operand mux consumes in the following cycle.
- Detects load-use hazards and generates stall, bubble and flush controls for the IF/ID/EX pipeline registers.

Parameters:
- REG_AW, 5, register index width.
- LOAD_STALL, 1, bubbles inserted on a load-use hazard (1..3).

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  synchronous, active-high reset.
- D_valid  in  1  decode slot holds a real instruction.
- D_rs1  in  REG_AW  decode rs1 index.
- D_rs2  in  REG_AW  decode rs2 index.
- D_use_rs1  in  1  instruction reads rs1.
- D_use_rs2  in  1  instruction reads rs2.
- D_rd  in  REG_AW  decode destination index.
- D_reg_write  in  1  instruction writes rd.
- D_is_load  in  1  instruction is a load.
- E_branch_taken  in  1  execute stage redirects the PC this cycle.
- stall_if  out  1  hold PC and IF/ID register.
- stall_id  out  1  hold the decode slot.
- bubble_ex  out  1  load a NOP into ID/EX.
- flush_id  out  1  squash IF/ID contents.
- E_rs1_data_sel  out  2  registered operand-1 select.
- E_rs2_data_sel  out  2  registered operand-2 select.

Behaviour:
- Select encoding:
  - 00 = wb_data (W-stage result).
  - 01 = alu_out (M-stage result).
  - 10 = register-file value.
  - 11 = constant zero.
- Scoreboard registers:
  - E stage: E_rd, E_wen, E_load.
  - M stage: M_rd, M_wen, M_load.
  - Each edge: M <= E. E <= decode instruction, or NOP (wen=0, load=0) when bubble or flush is applied.
- The register file is write-first; a W-stage write is visible to the decode read in the same cycle, so the unit does not track W.
- Select computation per source s, for the instruction in decode (it reaches E at the next edge), in priority order:
  - index 0 or use_s=0 -> 11.
  - else E_wen && E_rd==idx && !E_load -> 01 (E becomes M, result on alu_out).
  - else M_wen && M_rd==idx -> 00 (M becomes W, result on wb_data; covers loads).
  - else -> 10.
- Load-use hazard:
  - Condition: D_valid && E_load && E_wen && E_rd!=0 && E_rd matches a used source.
  - Response: stall_if=stall_id=bubble_ex=1 combinationally.
  - A down-counter loads LOAD_STALL-1 and holds stall while nonzero. The condition is not re-evaluated during the countdown.
  - With LOAD_STALL=1 the stall lasts exactly one cycle. The next cycle recomputes with the load in M and selects 00.
- Select registers:
  - Update to the computed values on every non-stalled edge.
  - During a stall, load 10/10 alongside the bubble.
- Flush:
  - E_branch_taken drives flush_id=1 and bubble_ex=1 in the same cycle.
  - The E entry becomes a NOP and the selects go to 11/11.
  - The stall counter clears.
  - Flush overrides stall: stall_if/stall_id are forced to 0.
- D_valid=0: treated as a NOP (no hazard; enters E with wen=0).
- Reset:
  - All scoreboard valid/wen/load bits = 0; counter = 0.
  - E_rs1_data_sel = E_rs2_data_sel = 10.
  - All stall/bubble/flush outputs = 0.
  - Reset asserted mid-stall aborts the stall at the next edge.
- Combinational outputs (stall_if, stall_id, bubble_ex, flush_id) have zero latency. The selects have one-cycle latency, aligned with the instruction's E cycle.

Decomposition:
- Shared pipeline package holds:
  - FWD_WB=2'b00, FWD_ALU=2'b01, FWD_RF=2'b10, FWD_ZERO=2'b11.
  - REG_AW.
  - The scoreboard entry struct {rd, wen, load}.
- One natural sub-module, fwd_select: the combinational priority compare for a single source. Instantiate it twice.

Test Plan:
- ALU back-to-back: add x5; then sub x6,x5,x1 -> E_rs1_data_sel=01, E_rs2_data_sel=10 one cycle after sub decodes; no stall.
- Distance-2: add x5; nop; or x7,x5,x5 -> both selects 00.
- Load-use: lw x8; add x9,x8,x2 -> stall_if/stall_id/bubble_ex high exactly one cycle; then select rs1=00. With LOAD_STALL=2 -> exactly two cycles.
- x0 guard: addi x0; then add x3,x0,x0 -> selects 11/11; no stall even if the preceding instruction is lw x0.
- Flush during load-use stall: lw x8; add x9,x8,x2 with E_branch_taken in the stall cycle -> flush_id=1, stall_if=0, selects 11/11, counter cleared.
- Reset mid-stall (LOAD_STALL=3) -> after rst edge all outputs 0, selects 10/10, no residual stall.
